// File: rtl/bin2bcd_if.sv
// Handshake bundle between the binary datapath, the bin2bcd converter and the readout logic.
// The slave modport is the converter side; the master modport is the producer/consumer side.
interface bin2bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic                  busy;

  modport slave (
    input  in_valid,
    input  bin_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd_out,
    output overflow,
    output busy
  );

  modport master (
    output in_valid,
    output bin_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd_out,
    input  overflow,
    input  busy
  );
endinterface

// File: rtl/bin2bcd_conv.sv
// Multi-cycle binary to packed-BCD converter (shift-and-add-3), one input bit per clock.
// A word is accepted in IDLE, shifted MSB-first for BIN_W cycles, then held until consumed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a word; in_ready=1
// S_SHIFT | one double-dabble step per clock; busy=1
// S_DONE  | result held on bcd_out/overflow; out_valid=1 until taken
module bin2bcd_conv #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic [DIGITS-1:0][3:0]   dig_q;
  logic [DIGITS-1:0][3:0]   dig_nxt;
  logic [BIN_W-1:0]         sh_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_q;
  logic                     top_cout;

  logic                     accept;
  logic                     deliver;
  logic                     shifting;
  logic                     last_step;

  assign accept    = (state_q == S_IDLE)  && bus.in_valid;
  assign deliver   = (state_q == S_DONE)  && bus.out_ready;
  assign shifting  = (state_q == S_SHIFT);
  assign last_step = (cnt_q == LAST_STEP);

  // One shift step: add-3 correction on each digit, then a ripple shift through the chain.
  always_comb begin : shift_step
    logic       c;
    logic [3:0] adj;
    dig_nxt = '0;
    c       = sh_q[BIN_W-1];
    adj     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj        = (dig_q[i] >= 4'd5) ? (dig_q[i] + 4'd3) : dig_q[i];
      dig_nxt[i] = {adj[2:0], c};
      c          = adj[3];
    end
    top_cout = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bus.busy = 1'b1;
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: the digit chain and overflow only move on accept (clear) or a shift step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q <= '0;
      sh_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      dig_q <= '0;
      sh_q  <= bus.bin_in;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (shifting) begin
      dig_q <= dig_nxt;
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q + 1'b1;
      ovf_q <= ovf_q | top_cout;
    end
  end

  assign bus.bcd_out  = dig_q;
  assign bus.overflow = ovf_q;

  logic unused_deliver;
  assign unused_deliver = deliver;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Randomized and directed scoreboard bench for bin2bcd_conv at DIGITS=5 and DIGITS=4.
// Expected results come from decimal division of the input value.
module tb_bin2bcd_conv;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2bcd_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
  bin2bcd_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

  bin2bcd_conv #(.BIN_W(16), .DIGITS(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  bin2bcd_conv #(.BIN_W(16), .DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int          errors = 0;
  int          checks = 0;
  logic [20:0] q5[$];
  logic [20:0] q4[$];
  logic [20:0] e5;
  logic [20:0] e4;
  bit          rand_ready = 1'b0;

  // {overflow, packed BCD of the low nd decimal digits}
  function automatic logic [20:0] model(input int unsigned v, input int nd);
    logic [19:0] b;
    int unsigned x;
    b = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {(x != 0), b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus5.out_valid && bus5.out_ready) begin
      checks++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL dut5_unexpected_result: got %h expected none", {bus5.overflow, bus5.bcd_out});
      end else begin
        e5 = q5.pop_front();
        if ({bus5.overflow, bus5.bcd_out} !== e5) begin
          errors++;
          $display("FAIL dut5_result: got %h expected %h", {bus5.overflow, bus5.bcd_out}, e5);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL dut4_unexpected_result: got %h expected none", {bus4.overflow, bus4.bcd_out});
      end else begin
        e4 = q4.pop_front();
        if ({bus4.overflow, 4'h0, bus4.bcd_out} !== e4) begin
          errors++;
          $display("FAIL dut4_result: got %h expected %h", {bus4.overflow, 4'h0, bus4.bcd_out}, e4);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus5.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send5(input logic [15:0] v);
    int n = 0;
    while (!bus5.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("dut5_accept_wait", {31'd0, bus5.in_ready}, 32'd1);
    bus5.in_valid = 1'b1;
    bus5.bin_in   = v;
    @(posedge clk);
    q5.push_back(model(v, 5));
    #1;
    bus5.in_valid = 1'b0;
    bus5.bin_in   = 16'($urandom);
  endtask

  task automatic send4(input logic [15:0] v);
    int n = 0;
    while (!bus4.in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("dut4_accept_wait", {31'd0, bus4.in_ready}, 32'd1);
    bus4.in_valid = 1'b1;
    bus4.bin_in   = v;
    @(posedge clk);
    q4.push_back(model(v, 4));
    #1;
    bus4.in_valid = 1'b0;
    bus4.bin_in   = 16'($urandom);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((q5.size() != 0 || q4.size() != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    check("drain_q5", q5.size(), 32'd0);
    check("drain_q4", q4.size(), 32'd0);
  endtask

  initial begin
    bus5.in_valid = 1'b0; bus5.bin_in = '0; bus5.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.bin_in = '0; bus4.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, bus5.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus5.out_valid}, 32'd0);
    check("rst_busy",      {31'd0, bus5.busy},      32'd0);
    check("rst_bcd",       {12'd0, bus5.bcd_out},   32'd0);
    check("rst_overflow",  {31'd0, bus5.overflow},  32'd0);
    rst_n = 1'b1;
    bus5.out_ready = 1'b1;
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;

    // Zero input and first-result latency
    send5(16'd0);
    repeat (15) @(posedge clk);
    #1;
    check("latency_before", {31'd0, bus5.out_valid}, 32'd0);
    @(posedge clk); #1;
    check("latency_at",     {31'd0, bus5.out_valid}, 32'd1);

    send5(16'd65535);
    send5(16'd12345);

    // Back-to-back
    send5(16'd999);
    check("b2b_busy",     {31'd0, bus5.busy},     32'd1);
    check("b2b_in_ready", {31'd0, bus5.in_ready}, 32'd0);
    send5(16'd1000);
    check("b2b_busy2",    {31'd0, bus5.busy},     32'd1);
    drain(100);

    // Consumer stall with an ignored input pulse
    bus5.out_ready = 1'b0;
    send5(16'd4321);
    begin
      int n = 0;
      while (!bus5.out_valid && n < 100) begin
        @(posedge clk); #1; n++;
      end
    end
    check("stall_valid", {31'd0, bus5.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus5.in_valid = 1'b1;
      bus5.bin_in   = 16'd7777;
      @(posedge clk); #1;
      check("stall_bcd",      {12'd0, bus5.bcd_out},   32'h04321);
      check("stall_in_ready", {31'd0, bus5.in_ready},  32'd0);
      check("stall_valid_hold", {31'd0, bus5.out_valid}, 32'd1);
    end
    bus5.in_valid  = 1'b0;
    bus5.out_ready = 1'b1;
    send5(16'd6789);

    // Narrow instance: boundary and overflow recovery
    send4(16'd9999);
    send4(16'd10000);
    send4(16'd42);
    drain(100);

    // Asynchronous reset in the middle of a conversion
    send5(16'd1234);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, bus5.in_ready},  32'd1);
    check("abort_busy",      {31'd0, bus5.busy},      32'd0);
    check("abort_out_valid", {31'd0, bus5.out_valid}, 32'd0);
    check("abort_bcd",       {12'd0, bus5.bcd_out},   32'd0);
    check("abort_overflow",  {31'd0, bus5.overflow},  32'd0);
    q5.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    send5(16'd255);
    drain(100);

    // Randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send5(16'($urandom));
      if (i % 3 == 0) send4(16'($urandom));
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    bus5.out_ready = 1'b1;
    drain(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_conv.md
Name: bin2bcd_conv

Overview:
- Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
- Accepts a binary word over a valid/ready handshake and shifts it MSB-first through an internal chain of DIGITS 4-bit BCD segments.
- Holds the packed BCD result under a valid/ready output handshake.
- Sits between the binary datapath and the display/readout formatting logic.

Parameters:
- BIN_W, 16: width of the binary input; also the number of shift cycles per conversion.
- DIGITS, 5: number of BCD digits produced; must be >= 1; overflow is flagged if too small.

Ports:
- clk  input  1  global clock; all state updates on the rising edge.
- rst_n  input  1  global reset, asynchronous, active-low.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  block can accept a new word; high only in IDLE.
- bin_in  input  BIN_W  unsigned binary value to convert.
- out_valid  output  1  bcd_out and overflow hold a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- overflow  output  1  result exceeded DIGITS digits; valid when out_valid=1.
- busy  output  1  conversion in progress (SHIFT state).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all digit registers=0; shift register=0; bit counter=0; in_ready=1 once state is IDLE; out_valid=0; busy=0; overflow=0; bcd_out=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: load bin_in into the BIN_W shift register, clear all digits and overflow, set counter=0, go to SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - Each edge performs one shift step and increments the counter.
  - After the BIN_W-th step, go to DONE.
- Shift step, per digit i:
  - adj = (d_i >= 5) ? d_i + 3 : d_i, computed in 4-bit arithmetic.
  - d_i <= {adj[2:0], cin_i}; cout_i = adj[3].
  - cin_0 = shift-register MSB; cin_i = cout_(i-1).
  - Shift register shifts left with 0 fill.
  - overflow <= overflow | cout_(DIGITS-1), i.e. sticky.
- DONE:
  - out_valid=1; bcd_out and overflow held stable until out_valid & out_ready.
  - On that handshake edge, go to IDLE.
  - in_ready=0 in DONE; there is no overlap of accept and deliver.
- Latency:
  - Accept at edge 0; out_valid is high in the cycle after edge BIN_W, i.e. BIN_W cycles after the accept edge.
  - Throughput is one word per BIN_W+2 cycles minimum, with out_ready tied high.
- Input handshake rules:
  - in_valid outside IDLE is ignored; bin_in is sampled only on the accept edge.
  - Changes to bin_in after acceptance have no effect.
- bcd_out is driven directly from the digit registers.
  - Mid-conversion values are undefined to the consumer; only qualify them with out_valid.
- out_ready outside DONE is ignored.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately; the result is discarded and all outputs return to reset values.
- BIN_W=1 is legal: one shift step.
- All-ones input must produce correct BCD when DIGITS is sufficient.
- Digit values are always 0..9 when overflow=0.

Test Plan:
- BIN_W=16, DIGITS=5, bin_in=0 -> out_valid 16 cycles after accept, bcd_out=20'h00000, overflow=0.
- bin_in=16'd65535 -> bcd_out=20'h65535; bin_in=16'd12345 -> bcd_out=20'h12345; overflow=0 both.
- out_ready held low 5 cycles in DONE; in_valid pulsed with a new value meanwhile:
  - bcd_out stable, in_ready=0, new value ignored.
  - After out_ready=1 -> IDLE, next accept then converts correctly.
- Back-to-back with out_ready=1: 999 then 1000 -> 20'h00999 then 20'h01000; in_ready low during SHIFT/DONE.
- DIGITS=4: bin_in=9999 -> 16'h9999, overflow=0; bin_in=10000 -> overflow=1, low digits 16'h0000; next conversion of 42 -> overflow=0, 16'h0042.
- rst_n pulsed low asynchronously at shift step 7:
  - Outputs go to reset values immediately, state IDLE.
  - Subsequent conversion of 255 -> 20'h00255.
